expand1x1_sched: RTL

- Sequencer for one fire expand 1x1 stage.
- Each output pixel takes one activation vector from the squeeze buffer.
- It then sweeps the combinational 64-lane weight ROM address 0..DEPTH-1 and drives MAC-array enable, accumulator-clear and last flags.
- It waits out the MAC pipeline, then hands the 64 results to the writeback stage through a valid/ready handshake.

---
 rtl/expand1x1_sched_pkg.sv | 40 ++++
 rtl/expand1x1_sched_cnt.sv | 55 +++++
 rtl/expand1x1_sched.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/expand1x1_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : expand_pkg
// Purpose  : Shared types and layer constants for the fire expand 1x1
//            scheduler. Provides the scheduler state enum, the default
//            per-fire-stage layer constants and a counter width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package expand_pkg;

  // Scheduler states. The encoding is explicit so it stays stable in dumps.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    WB    = 3'd4,
    DONE  = 3'd5
  } sched_state_t;

  // Default layer constants per fire stage (55x55 maps for fire2/fire3,
  // 27x27 for fire4/fire5).
  localparam int unsigned FIRE2_DEPTH   = 16;
  localparam int unsigned FIRE2_PIXELS  = 3025;
  localparam int unsigned FIRE2_MAC_LAT = 2;
  localparam int unsigned FIRE3_DEPTH   = 16;
  localparam int unsigned FIRE3_PIXELS  = 3025;
  localparam int unsigned FIRE3_MAC_LAT = 2;
  localparam int unsigned FIRE4_DEPTH   = 32;
  localparam int unsigned FIRE4_PIXELS  = 729;
  localparam int unsigned FIRE4_MAC_LAT = 2;

  // Bits needed to hold values 0..last_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned last_val);
    return (last_val < 2) ? 1 : $clog2(last_val + 1);
  endfunction

endpackage : expand_pkg
`default_nettype wire

// File: rtl/expand1x1_sched_cnt.sv
`default_nettype none
// ============================================================================
// Module   : sched_cnt
// Purpose  : Parameterised up-counter with synchronous clear, count enable
//            and terminal-count flag. Counting past LAST wraps to zero, so a
//            sweep counter is back at 0 as soon as its sweep finishes.
// Ports    : clk    - clock
//            rst    - asynchronous active-high reset
//            clr_i  - synchronous clear (priority over enable)
//            en_i   - count enable
//            cnt_o  - current count (registered)
//            tc_o   - high while cnt_o == LAST
// Revision : 1.0 - initial release
// ============================================================================
module sched_cnt
  import expand_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LAST  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign tc_o  = (cnt_q == LAST_V);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : sched_cnt
`default_nettype wire

// File: rtl/expand1x1_sched.sv
`default_nettype none
// ============================================================================
// Module   : expand1x1_sched
// Purpose  : Sequencer for one fire expand 1x1 stage. Per output pixel it
//            accepts one activation vector, sweeps the weight ROM address
//            0..DEPTH-1 with MAC enable / clear / last flags, waits out the
//            MAC pipeline and hands the results to writeback via valid/ready.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            start_i         - one-cycle pulse starting a layer run
//            busy_o, done_o  - run in progress / one-cycle completion pulse
//            act_valid_i/act_ready_o - activation vector handshake
//            rom_addr_o      - weight ROM address
//            mac_en_o, acc_clr_o, acc_last_o - MAC array controls
//            wb_valid_o/wb_ready_i - writeback handshake
//            pixel_idx_o     - pixel in flight
//            stall_cnt_o     - stall cycle counter (EXPAND1X1_SCHED_PERF_EN)
// Options  : `define EXPAND1X1_SCHED_PERF_EN adds the stall_cnt_o port.
// Revision : 1.0 - initial release
// ============================================================================
module expand1x1_sched
  import expand_pkg::*;
#(
  parameter int unsigned ADDR    = 4,
  parameter int unsigned DEPTH   = FIRE2_DEPTH,
  parameter int unsigned PIXELS  = FIRE2_PIXELS,
  parameter int unsigned PIX_W   = 12,
  parameter int unsigned MAC_LAT = FIRE2_MAC_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic             act_valid_i,
  output logic             act_ready_o,
  output logic [ADDR-1:0]  rom_addr_o,
  output logic             mac_en_o,
  output logic             acc_clr_o,
  output logic             acc_last_o,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [PIX_W-1:0] pixel_idx_o
`ifdef EXPAND1X1_SCHED_PERF_EN
  ,
  output logic [31:0]      stall_cnt_o
`endif
);

  localparam int unsigned DRN_W     = cnt_width(MAC_LAT - 1);
  localparam logic [ADDR:0] LAST_ADDR = (ADDR + 1)'(DEPTH - 1);
  localparam logic          DEPTH_ONE = (DEPTH == 1);

  sched_state_t state_q, state_d;

  logic busy_q,      busy_d;
  logic done_q,      done_d;
  logic act_ready_q, act_ready_d;
  logic mac_en_q,    mac_en_d;
  logic acc_clr_q,   acc_clr_d;
  logic acc_last_q,  acc_last_d;
  logic wb_valid_q,  wb_valid_d;

  logic [ADDR-1:0]  rom_q;
  logic             rom_tc;
  logic [DRN_W-1:0] drn_q;
  logic             drn_tc;
  logic [PIX_W-1:0] pix_q;
  logic             pix_tc;

  logic             start_acc;
  logic             act_acc;
  logic             wb_xfer;
  logic [ADDR:0]    rom_inc;
  logic             next_is_last;

  // Start is only honoured from IDLE; a pulse during a run is dropped.
  assign start_acc = (state_q == IDLE) && start_i;
  assign act_acc   = (state_q == LOAD) && act_valid_i && act_ready_q;
  assign wb_xfer   = (state_q == WB) && wb_valid_q && wb_ready_i;

  // --------------------------------------------------------------------------
  // Counters: ROM sweep, drain wait and pixel index
  // --------------------------------------------------------------------------
  sched_cnt #(.WIDTH(ADDR), .LAST(DEPTH - 1)) u_rom_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start_acc),
    .en_i  (state_q == MAC),
    .cnt_o (rom_q),
    .tc_o  (rom_tc)
  );

  sched_cnt #(.WIDTH(DRN_W), .LAST(MAC_LAT - 1)) u_drn_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start_acc),
    .en_i  (state_q == DRAIN),
    .cnt_o (drn_q),
    .tc_o  (drn_tc)
  );

  // The pixel counter never advances past the last pixel, so it only
  // returns to zero through the clear on a new start.
  sched_cnt #(.WIDTH(PIX_W), .LAST(PIXELS - 1)) u_pix_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start_acc),
    .en_i  (wb_xfer && !pix_tc),
    .cnt_o (pix_q),
    .tc_o  (pix_tc)
  );

  // --------------------------------------------------------------------------
  // FSM: state and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      act_ready_q <= 1'b0;
      mac_en_q    <= 1'b0;
      acc_clr_q   <= 1'b0;
      acc_last_q  <= 1'b0;
      wb_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      act_ready_q <= act_ready_d;
      mac_en_q    <= mac_en_d;
      acc_clr_q   <= acc_clr_d;
      acc_last_q  <= acc_last_d;
      wb_valid_q  <= wb_valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_acc) state_d = LOAD;
      LOAD:    if (act_acc)   state_d = MAC;
      MAC:     if (rom_tc)    state_d = DRAIN;
      DRAIN:   if (drn_tc)    state_d = WB;
      WB:      if (wb_xfer)   state_d = pix_tc ? DONE : LOAD;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. Every flag is decoded from the next state so that the
  // registered outputs line up with the state they describe.
  // --------------------------------------------------------------------------
  // rom_inc is the address the ROM counter holds after this edge when a
  // MAC cycle continues; a sweep entered from LOAD always starts at 0.
  assign rom_inc      = {1'b0, rom_q} + (ADDR + 1)'(1);
  assign next_is_last = (state_q == LOAD) ? DEPTH_ONE : (rom_inc == LAST_ADDR);

  always_comb begin
    busy_d      = (state_d == LOAD) || (state_d == MAC) ||
                  (state_d == DRAIN) || (state_d == WB);
    done_d      = (state_d == DONE);
    act_ready_d = (state_d == LOAD);
    mac_en_d    = (state_d == MAC);
    acc_clr_d   = (state_q == LOAD) && (state_d == MAC);
    acc_last_d  = (state_d == MAC) && next_is_last;
    wb_valid_d  = (state_d == WB);
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign act_ready_o = act_ready_q;
  assign mac_en_o    = mac_en_q;
  assign acc_clr_o   = acc_clr_q;
  assign acc_last_o  = acc_last_q;
  assign wb_valid_o  = wb_valid_q;
  assign rom_addr_o  = rom_q;
  assign pixel_idx_o = pix_q;

`ifdef EXPAND1X1_SCHED_PERF_EN
  // Stall cycles: waiting for an activation in LOAD or for writeback in WB.
  logic [31:0] stall_q;
  logic [31:0] stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_acc) begin
      stall_d = '0;
    end else if ((((state_q == LOAD) && !act_valid_i) ||
                  ((state_q == WB) && !wb_ready_i)) && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule : expand1x1_sched
`default_nettype wire
